// File: rtl/ex_hilo_if.sv
// EX-stage HI/LO unit bus: operands and op code toward the unit, HI/LO
// write-back fields and stall request back toward the EX/MEM register.
interface ex_hilo_if;
  logic [3:0]  hilo_op_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        annul_i;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  modport master (
    output hilo_op_i, reg1_i, reg2_i, hi_i, lo_i, annul_i,
    input  whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  hilo_op_i, reg1_i, reg2_i, hi_i, lo_i, annul_i,
    output whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_hilo.sv
// HI/LO arithmetic unit of the EX stage: MTHI/MTLO, MULT(U), two-cycle
// MADD/MSUB family and a restoring radix-2 DIV/DIVU that stalls the pipe.
module ex_hilo #(
  parameter int DIV_BITS = 32
) (
  input logic     clk,
  input logic     rst,
  ex_hilo_if.slave bus
);

  localparam logic [3:0] OP_MTHI  = 4'd1;
  localparam logic [3:0] OP_MTLO  = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_DIV   = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;

  localparam int             CW        = (DIV_BITS > 1) ? $clog2(DIV_BITS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ZERO = 2'd1,
    ST_ON   = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  div_state_e     state_q, state_d;
  logic           madd_cnt_q, madd_cnt_d;
  logic [63:0]    prod_q, prod_d;
  logic [31:0]    dvd_q, dvd_d;
  logic [31:0]    dvs_q, dvs_d;
  logic [31:0]    rem_q, rem_d;
  logic [CW-1:0]  iter_q, iter_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;

  logic           is_div_s;
  logic           div_signed_s;
  logic           is_madd_s;
  logic           madd_signed_s;
  logic           madd_sub_s;
  logic [63:0]    smul_s;
  logic [63:0]    umul_s;
  logic [63:0]    madd_acc_s;
  logic [31:0]    abs1_s;
  logic [31:0]    abs2_s;
  logic [32:0]    shifted_s;
  logic           fits_s;
  logic [31:0]    diff_s;
  logic [31:0]    quo_out_s;
  logic [31:0]    rem_out_s;

  logic           whilo_s;
  logic           stall_s;
  logic [31:0]    hi_s;
  logic [31:0]    lo_s;

  // Op decode, multipliers, divider datapath and signed result fix-up.
  always_comb begin
    is_div_s      = (bus.hilo_op_i == OP_DIV) || (bus.hilo_op_i == OP_DIVU);
    div_signed_s  = (bus.hilo_op_i == OP_DIV);
    is_madd_s     = (bus.hilo_op_i == OP_MADD) || (bus.hilo_op_i == OP_MADDU) ||
                    (bus.hilo_op_i == OP_MSUB) || (bus.hilo_op_i == OP_MSUBU);
    madd_signed_s = (bus.hilo_op_i == OP_MADD) || (bus.hilo_op_i == OP_MSUB);
    madd_sub_s    = (bus.hilo_op_i == OP_MSUB) || (bus.hilo_op_i == OP_MSUBU);

    // Low 64 bits of the product of sign-extended operands is the signed product.
    smul_s = {{32{bus.reg1_i[31]}}, bus.reg1_i} * {{32{bus.reg2_i[31]}}, bus.reg2_i};
    umul_s = {32'd0, bus.reg1_i} * {32'd0, bus.reg2_i};

    madd_acc_s = madd_sub_s ? ({bus.hi_i, bus.lo_i} - prod_q)
                            : ({bus.hi_i, bus.lo_i} + prod_q);

    abs1_s = (div_signed_s && bus.reg1_i[31]) ? (32'd0 - bus.reg1_i) : bus.reg1_i;
    abs2_s = (div_signed_s && bus.reg2_i[31]) ? (32'd0 - bus.reg2_i) : bus.reg2_i;

    // Partial remainder stays below the divisor, so only its low 31 bits shift up.
    shifted_s = {rem_q, dvd_q[31]};
    fits_s    = (shifted_s >= {1'b0, dvs_q});
    diff_s    = {rem_q[30:0], dvd_q[31]} - dvs_q;

    quo_out_s = neg_quo_q ? (32'd0 - dvd_q) : dvd_q;
    rem_out_s = neg_rem_q ? (32'd0 - rem_q) : rem_q;
  end

  // Next-state logic for the divider FSM and the MADD/MSUB cycle count.
  always_comb begin
    state_d    = state_q;
    madd_cnt_d = madd_cnt_q;
    prod_d     = prod_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    iter_d     = iter_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;

    if (bus.annul_i) begin
      state_d    = ST_IDLE;
      madd_cnt_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_madd_s) begin
            madd_cnt_d = ~madd_cnt_q;
            if (!madd_cnt_q) begin
              prod_d = madd_signed_s ? smul_s : umul_s;
            end else begin
              prod_d = prod_q;
            end
          end else begin
            madd_cnt_d = 1'b0;
          end

          if (is_div_s) begin
            if (bus.reg2_i == 32'd0) begin
              state_d = ST_ZERO;
            end else begin
              dvd_d     = abs1_s;
              dvs_d     = abs2_s;
              rem_d     = 32'd0;
              iter_d    = {CW{1'b0}};
              neg_quo_d = div_signed_s && (bus.reg1_i[31] ^ bus.reg2_i[31]);
              neg_rem_d = div_signed_s && bus.reg1_i[31];
              state_d   = ST_ON;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ZERO: begin
          dvd_d     = 32'd0;
          rem_d     = 32'd0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          state_d   = ST_DONE;
        end
        ST_ON: begin
          if (fits_s) begin
            rem_d = diff_s;
            dvd_d = {dvd_q[30:0], 1'b1};
          end else begin
            rem_d = shifted_s[31:0];
            dvd_d = {dvd_q[30:0], 1'b0};
          end
          if (iter_q == LAST_ITER) begin
            state_d = ST_DONE;
          end else begin
            iter_d = iter_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output selection; reset and annul both silence every output.
  always_comb begin
    whilo_s = 1'b0;
    stall_s = 1'b0;
    hi_s    = 32'd0;
    lo_s    = 32'd0;

    if (!rst) begin
      whilo_s = 1'b0;
    end else if (bus.annul_i) begin
      whilo_s = 1'b0;
    end else if (state_q != ST_IDLE) begin
      case (state_q)
        ST_ZERO, ST_ON: begin
          stall_s = 1'b1;
        end
        ST_DONE: begin
          whilo_s = 1'b1;
          hi_s    = rem_out_s;
          lo_s    = quo_out_s;
        end
        default: begin
          stall_s = 1'b0;
        end
      endcase
    end else begin
      case (bus.hilo_op_i)
        OP_MTHI: begin
          whilo_s = 1'b1;
          hi_s    = bus.reg1_i;
          lo_s    = bus.lo_i;
        end
        OP_MTLO: begin
          whilo_s = 1'b1;
          hi_s    = bus.hi_i;
          lo_s    = bus.reg1_i;
        end
        OP_MULT: begin
          whilo_s      = 1'b1;
          {hi_s, lo_s} = smul_s;
        end
        OP_MULTU: begin
          whilo_s      = 1'b1;
          {hi_s, lo_s} = umul_s;
        end
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
          if (!madd_cnt_q) begin
            stall_s = 1'b1;
          end else begin
            whilo_s      = 1'b1;
            {hi_s, lo_s} = madd_acc_s;
          end
        end
        OP_DIV, OP_DIVU: begin
          stall_s = 1'b1;
        end
        default: begin
          whilo_s = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      madd_cnt_q <= 1'b0;
      prod_q     <= 64'd0;
      dvd_q      <= 32'd0;
      dvs_q      <= 32'd0;
      rem_q      <= 32'd0;
      iter_q     <= {CW{1'b0}};
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      madd_cnt_q <= madd_cnt_d;
      prod_q     <= prod_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      iter_q     <= iter_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign bus.whilo_o    = whilo_s;
  assign bus.stallreq_o = stall_s;
  assign bus.hi_o       = hi_s;
  assign bus.lo_o       = lo_s;

endmodule
